dcache_sa: RTL and testbench

Parametrised set-associative, write-back, write-allocate data cache between the MEM stage and the line-granular memory port. Generalises the fixed 2-set/2-way design to power-of-two sets, ways and line size. Adds a valid/ready request interface, unsigned loads, misalignment reporting and deterministic round-robin replacement. Back-to-back hits sustain one access per cycle; misses stall by holding `req_ready` low.

---
 rtl/dcache_if.sv | 28 ++
 rtl/dcache_sa.sv | 201 ++++++++++++++++++++
 tb/tb_dcache_sa.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// dcache_if: request/response and line-memory bus of the set-associative data cache
interface dcache_if #(parameter int LINE_BYTES = 16);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [31:0]             req_addr;
  logic [31:0]             req_wdata;
  logic [2:0]              req_funct3;
  logic                    resp_valid;
  logic [31:0]             resp_rdata;
  logic                    resp_misaligned;
  logic                    mem_read_en;
  logic                    mem_write_en;
  logic [31:0]             mem_addr;
  logic [8*LINE_BYTES-1:0] mem_wdata;
  logic [8*LINE_BYTES-1:0] mem_rdata;
  logic                    mem_ready;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, mem_rdata, mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_read_en, mem_write_en, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, mem_rdata, mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_read_en, mem_write_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_sa.sv
// dcache_sa: set-associative write-back/write-allocate data cache; DCACHE_STATS_EN adds hit/miss/writeback counters
module dcache_sa #(
  parameter int LINE_BYTES = 16,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_writebacks
`endif
);
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS;
  localparam int WAY_BITS    = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
  localparam int LINE_W      = 8 * LINE_BYTES;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t state_q, state_d;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS], valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS], dirty_d [NUM_SETS];
  logic [WAY_BITS-1:0] rr_q    [NUM_SETS], rr_d    [NUM_SETS];
  logic [TAG_BITS-1:0] tag_q   [NUM_SETS][NUM_WAYS], tag_d  [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS], data_d [NUM_SETS][NUM_WAYS];
  logic [31:0]         addr_q, addr_d, wdata_q, wdata_d, resp_rdata_q, resp_rdata_d;
  logic [2:0]          f3_q, f3_d;
  logic [WAY_BITS-1:0] way_q, way_d, hit_way, vic_way;
  logic                write_q, write_d, from_rr_q, from_rr_d;
  logic                resp_valid_q, resp_valid_d, resp_mis_q, resp_mis_d;
  logic                acc, hit, vic_found, is_b, is_h, mis;
  logic [OFFSET_BITS-1:0] req_off, l_off;
  logic [INDEX_BITS-1:0]  req_idx, l_idx;
  logic [TAG_BITS-1:0]    req_tag;
  function automatic logic [31:0] load_ext(input logic [LINE_W-1:0] line,
                                           input logic [OFFSET_BITS-1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] w;
    w = 32'(line >> {off, 3'b000});
    return f3 == 3'b000 ? {{24{w[7]}}, w[7:0]} :
           f3 == 3'b001 ? {{16{w[15]}}, w[15:0]} :
           f3 == 3'b100 ? {24'b0, w[7:0]} :
           f3 == 3'b101 ? {16'b0, w[15:0]} : w;
  endfunction
  function automatic logic [LINE_W-1:0] store_merge(input logic [LINE_W-1:0] line,
                                                    input logic [OFFSET_BITS-1:0] off,
                                                    input logic [31:0] wdata,
                                                    input logic [2:0] f3);
    logic [LINE_BYTES-1:0] m;
    logic [LINE_W-1:0]     d, r;
    m = LINE_BYTES'(f3 == 3'b000 ? 4'b0001 : f3 == 3'b001 ? 4'b0011 : 4'b1111) << off;
    d = LINE_W'(wdata) << {off, 3'b000};
    for (int k = 0; k < LINE_BYTES; k++) r[8*k+:8] = m[k] ? d[8*k+:8] : line[8*k+:8];
    return r;
  endfunction
  assign req_off = bus.req_addr[OFFSET_BITS-1:0];
  assign req_idx = bus.req_addr[OFFSET_BITS+:INDEX_BITS];
  assign req_tag = bus.req_addr[31-:TAG_BITS];
  assign l_off   = addr_q[OFFSET_BITS-1:0];
  assign l_idx   = addr_q[OFFSET_BITS+:INDEX_BITS];
  assign acc     = bus.req_valid && bus.req_ready;
  assign is_b    = bus.req_funct3 == 3'b000 || (!bus.req_write && bus.req_funct3 == 3'b100);
  assign is_h    = bus.req_funct3 == 3'b001 || (!bus.req_write && bus.req_funct3 == 3'b101);
  assign mis     = is_h ? bus.req_addr[0] : !is_b && bus.req_addr[1:0] != 2'b00;
  assign bus.req_ready       = state_q == IDLE && !reset;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.resp_misaligned = resp_mis_q;
  assign bus.mem_write_en    = state_q == WRITEBACK;
  assign bus.mem_read_en     = state_q == FILL;
  assign bus.mem_wdata       = state_q == WRITEBACK ? data_q[l_idx][way_q] : '0;
  assign bus.mem_addr        = state_q == WRITEBACK ? {tag_q[l_idx][way_q], l_idx, {OFFSET_BITS{1'b0}}} :
                               state_q == FILL ? {addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : '0;
  // tag lookup and victim choice: lowest invalid way wins, otherwise the set's round-robin pointer
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    vic_way   = rr_q[req_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[req_idx][w]) begin
        vic_found = 1'b1;
        vic_way   = WAY_BITS'(w);
      end
    end
  end
  // next state: hit/misaligned service in IDLE, writeback of a dirty victim, then refill with merged store
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    rr_d         = rr_q;
    tag_d        = tag_q;
    data_d       = data_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    f3_d         = f3_q;
    way_d        = way_q;
    from_rr_d    = from_rr_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_mis_d   = 1'b0;
    if (acc && mis) begin
      resp_valid_d = 1'b1;
      resp_mis_d   = 1'b1;
    end else if (acc && hit) begin
      resp_valid_d = 1'b1;
      if (bus.req_write) begin
        data_d[req_idx][hit_way]  = store_merge(data_q[req_idx][hit_way], req_off, bus.req_wdata, bus.req_funct3);
        dirty_d[req_idx][hit_way] = 1'b1;
      end else begin
        resp_rdata_d = load_ext(data_q[req_idx][hit_way], req_off, bus.req_funct3);
      end
    end else if (acc) begin
      addr_d    = bus.req_addr;
      wdata_d   = bus.req_wdata;
      write_d   = bus.req_write;
      f3_d      = bus.req_funct3;
      way_d     = vic_way;
      from_rr_d = !vic_found;
      state_d   = valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way] ? WRITEBACK : FILL;
    end
    if (state_q == WRITEBACK && bus.mem_ready) begin
      dirty_d[l_idx][way_q] = 1'b0;
      state_d               = FILL;
    end
    if (state_q == FILL && bus.mem_ready) begin
      data_d[l_idx][way_q]  = write_q ? store_merge(bus.mem_rdata, l_off, wdata_q, f3_q) : bus.mem_rdata;
      tag_d[l_idx][way_q]   = addr_q[31-:TAG_BITS];
      valid_d[l_idx][way_q] = 1'b1;
      dirty_d[l_idx][way_q] = write_q;
      if (from_rr_q) rr_d[l_idx] = rr_q[l_idx] == WAY_BITS'(NUM_WAYS - 1) ? '0 : rr_q[l_idx] + 1'b1;
      resp_valid_d = 1'b1;
      resp_rdata_d = write_q ? '0 : load_ext(bus.mem_rdata, l_off, f3_q);
      state_d      = IDLE;
    end
  end
  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '{default: '0};
      dirty_q      <= '{default: '0};
      rr_q         <= '{default: '0};
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      rr_q         <= rr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
    end
  end
  // data/tag arrays and the latched miss request carry no reset
  always_ff @(posedge clk) begin
    data_q    <= data_d;
    tag_q     <= tag_d;
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
    write_q   <= write_d;
    f3_q      <= f3_d;
    way_q     <= way_d;
    from_rr_q <= from_rr_d;
  end
`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d, wbs_q, wbs_d;
  // aligned accepted accesses split into hits and misses; writebacks counted on completion
  always_comb begin
    hits_d   = hits_q + 32'(acc && !mis && hit);
    misses_d = misses_q + 32'(acc && !mis && !hit);
    wbs_d    = wbs_q + 32'(state_q == WRITEBACK && bus.mem_ready);
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
    end
  end
  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;
  assign stat_writebacks = wbs_q;
`endif
endmodule

// File: tb/tb_dcache_sa.sv
// tb_dcache_sa: vector table + response scoreboard + line-memory responder for dcache_sa
module tb_dcache_sa;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  dcache_if #(.LINE_BYTES(16)) bus();
`ifdef DCACHE_STATS_EN
  logic [31:0] s_h, s_m, s_w;
`endif
  dcache_sa #(.LINE_BYTES(16), .NUM_SETS(4), .NUM_WAYS(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    , .stat_hits(s_h), .stat_misses(s_m), .stat_writebacks(s_w)
`endif
  );
  typedef struct {
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          mis;
    bit          wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_w1;
    bit          fill;
    logic [31:0] fill_addr;
  } vec_t;
  typedef struct { logic [31:0] rdata; logic mis; } exp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] w1; } mev_t;
  exp_t sb[$];
  mev_t mlog[$];
  vec_t vecs[$];
  logic [127:0] mem [logic [31:0]];
  int n_vec = 0;
  int n_err = 0;
  bit auto_resp = 1'b1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] r;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 16; k++) r[8*k+:8] = 8'((a >> 2) - 32'd16 + 32'(k));
    return r;
  endfunction
  function automatic vec_t mk(input bit wr, input logic [2:0] f3, input logic [31:0] addr, wdata, rdata,
                              input bit mis, wb, input logic [31:0] wb_addr, wb_w1,
                              input bit fill, input logic [31:0] fill_addr);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.mis = mis;
    v.wb = wb; v.wb_addr = wb_addr; v.wb_w1 = wb_w1; v.fill = fill; v.fill_addr = fill_addr;
    return v;
  endfunction
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_resp) begin
        bus.mem_ready = 1'b0;
        if (bus.mem_read_en || bus.mem_write_en) begin
          cnt++;
          if (cnt == 3) begin
            cnt = 0;
            mlog.push_back(mev_t'{bus.mem_write_en, bus.mem_addr, bus.mem_wdata[63:32]});
            if (bus.mem_write_en) mem[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata = line_of(bus.mem_addr);
            bus.mem_ready = 1'b1;
          end
        end else cnt = 0;
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
        end else begin
          e = sb.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_misaligned", 32'(bus.resp_misaligned), 32'(e.mis));
        end
      end
    end
  end
  task automatic run_vec(input vec_t v);
    int cyc;
    int i;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = v.wr; bus.req_addr = v.addr;
    bus.req_wdata = v.wdata; bus.req_funct3 = v.f3;
    cyc = 0;
    while (!bus.req_ready && cyc < 100) begin @(negedge clk); cyc++; end
    check("req_accept", 32'(bus.req_ready), 32'd1);
    sb.push_back(exp_t'{v.rdata, v.mis});
    mlog.delete();
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.resp_valid && cyc < 100) begin @(negedge clk); cyc++; end
    check("resp_seen", 32'(bus.resp_valid), 32'd1);
    if (!v.wb && !v.fill) begin
      check("hit_latency", 32'(cyc), 32'd1);
      check("ready_after_hit", 32'(bus.req_ready), 32'd1);
    end
    check("mem_events", 32'(mlog.size()), 32'(v.wb) + 32'(v.fill));
    if (mlog.size() == int'(v.wb) + int'(v.fill)) begin
      i = 0;
      if (v.wb) begin
        check("wb_is_write", 32'(mlog[0].wr), 32'd1);
        check("wb_addr", mlog[0].addr, v.wb_addr);
        check("wb_word1", mlog[0].w1, v.wb_w1);
        i = 1;
      end
      if (v.fill) begin
        check("fill_is_read", 32'(mlog[i].wr), 32'd0);
        check("fill_addr", mlog[i].addr, v.fill_addr);
      end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    vecs.push_back(mk(0, 3'b010, 32'h40,  0, 32'h03020100, 0, 0, 0, 0, 1, 32'h40));
    vecs.push_back(mk(0, 3'b000, 32'h43,  0, 32'h00000003, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 32'h4F,  0, 32'h0000000F, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h41,  32'h80, 0,       0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 32'h41,  0, 32'hFFFFFF80, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 32'h41,  0, 32'h00000080, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h44,  32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h42,  0, 0,            1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h41,  32'hABCD, 0,     1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h40,  0, 32'h03028000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h44,  0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h80,  0, 32'h13121110, 0, 0, 0, 0, 1, 32'h80));
    vecs.push_back(mk(0, 3'b010, 32'hC0,  0, 32'h23222120, 0, 1, 32'h40, 32'hDEADBEEF, 1, 32'hC0));
    vecs.push_back(mk(0, 3'b010, 32'hC4,  0, 32'h27262524, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h84,  0, 32'h17161514, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h106, 32'h1234, 0,     0, 0, 0, 0, 1, 32'h100));
    vecs.push_back(mk(0, 3'b101, 32'h106, 0, 32'h00001234, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h10A, 32'h8001, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b001, 32'h10A, 0, 32'hFFFF8001, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b101, 32'h10A, 0, 32'h00008001, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h200, 0, 32'h73727170, 0, 0, 0, 0, 1, 32'h200));
    vecs.push_back(mk(0, 3'b010, 32'h300, 0, 32'hB3B2B1B0, 0, 1, 32'h100, 32'h12343534, 1, 32'h300));
    vecs.push_back(mk(0, 3'b010, 32'h108, 0, 32'h80013938, 0, 0, 0, 0, 1, 32'h100));
    vecs.push_back(mk(0, 3'b010, 32'h50,  0, 32'h07060504, 0, 0, 0, 0, 1, 32'h50));
    vecs.push_back(mk(0, 3'b111, 32'h54,  0, 32'h0B0A0908, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_funct3 = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_mis", 32'(bus.resp_misaligned), 32'd0);
    check("rst_enables", {30'd0, bus.mem_read_en, bus.mem_write_en}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata_nz", 32'(bus.mem_wdata != '0), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
    auto_resp = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h400;
    bus.req_wdata = 32'hFFFF_FFFF; bus.req_funct3 = 3'b010;
    check("midfill_accept", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("miss_read_en", 32'(bus.mem_read_en), 32'd1);
    check("miss_write_en", 32'(bus.mem_write_en), 32'd0);
    check("miss_mem_addr", bus.mem_addr, 32'h400);
    @(negedge clk);
    check("read_en_held", 32'(bus.mem_read_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_read_en", 32'(bus.mem_read_en), 32'd0);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = '1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check("late_ready_resp", 32'(bus.resp_valid), 32'd0);
    check("late_ready_en", {30'd0, bus.mem_read_en, bus.mem_write_en}, 32'd0);
    check("late_ready_idle", 32'(bus.req_ready), 32'd1);
`ifdef DCACHE_STATS_EN
    check("stat_hits_rst", s_h, 32'd0);
    check("stat_misses_rst", s_m, 32'd0);
    check("stat_wbs_rst", s_w, 32'd0);
`endif
    repeat (2) @(negedge clk);
    auto_resp = 1'b1;
    run_vec(mk(0, 3'b010, 32'h400, 0, 32'hF3F2F1F0, 0, 0, 0, 0, 1, 32'h400));
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
